// File: rtl/decode_stage.sv
// RV32 decode stage: register-file read, operand capture,
// busy-bit scoreboard with RAW/WAW stalls and writeback forwarding.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [31:0]      in_instr,
   output logic             in_ready,
   output logic [4:0]       rf_rs1,
   output logic [4:0]       rf_rs2,
   input  logic [XLEN-1:0]  rf_read1,
   input  logic [XLEN-1:0]  rf_read2,
   output logic             rf_enable,
   output logic [4:0]       rf_rd,
   output logic [XLEN-1:0]  rf_write,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [4:0]       out_rd,
   output logic [XLEN-1:0]  out_op1,
   output logic [XLEN-1:0]  out_op2,
   output logic [XLEN-1:0]  out_imm,
   output logic [CNT_W-1:0] stall_count
);

   logic [31:0]     busy;
   logic [31:0]     busy_eff;
   logic [31:0]     wb_hit;
   logic [31:0]     set_hit;
   logic [31:0]     busy_nxt;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;
   logic [6:0]      opc;
   logic            writing;
   logic            hazard;
   logic            accept;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;

   function automatic logic [XLEN-1:0] opnd(
      input logic [4:0]      a,
      input logic [XLEN-1:0] rf,
      input logic            wv,
      input logic [4:0]      wr,
      input logic [XLEN-1:0] wd
   );
      if (a == 5'd0)
         return '0;
      else if (wv && wr == a)
         return wd;
      else
         return rf;
   endfunction

   assign rs1 = in_instr[19:15];
   assign rs2 = in_instr[24:20];
   assign rd  = in_instr[11:7];
   assign opc = in_instr[6:0];

   assign rf_rs1    = rs1;
   assign rf_rs2    = rs2;
   assign rf_enable = wb_valid && (wb_rd != 5'd0);
   assign rf_rd     = wb_rd;
   assign rf_write  = wb_data;

   assign writing = (opc != 7'b0100011) && (opc != 7'b1100011);

   // a same-cycle writeback releases its register for this decode
   assign wb_hit   = wb_valid ? (32'd1 << wb_rd) : 32'd0;
   assign busy_eff = busy & ~wb_hit;

   assign hazard = busy_eff[rs1] || busy_eff[rs2] ||
                   (writing && busy_eff[rd]);

   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   assign set_hit = (accept && writing && rd != 5'd0) ?
                    (32'd1 << rd) : 32'd0;

   always_comb begin
      busy_nxt    = (busy & ~wb_hit) | set_hit;
      busy_nxt[0] = 1'b0;
   end

   assign op1 = opnd(rs1, rf_read1, wb_valid, wb_rd, wb_data);
   assign op2 = opnd(rs2, rf_read2, wb_valid, wb_rd, wb_data);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_rd    <= '0;
         out_op1   <= '0;
         out_op2   <= '0;
         out_imm   <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_instr <= in_instr;
         out_rd    <= writing ? rd : 5'd0;
         out_op1   <= op1;
         out_op2   <= op2;
         out_imm   <= {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_count <= '0;
      else if (in_valid && hazard && stall_count != {CNT_W{1'b1}})
         stall_count <= stall_count + 1'b1;
   end

endmodule
